// File: rtl/left_rotate_reg_pkg.sv
// ============================================================================
// Module      : left_rotate_reg_pkg
// Description : Shared opcode encoding, decode helper and the width-generic
//               rotate-left-by-one macro for the left_rotate_reg datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Width-generic left rotate by one. The operand must be a plain identifier.
`define LEFT_ROTATE_REG_ROTL1(v, W) {v[(W)-2:0], v[(W)-1]}

package left_rotate_reg_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_ROT  = 2'd1,
        OP_LOAD = 2'd2
    } op_e;

    localparam int unsigned c_MIN_DW = 2;

    // Load outranks rotate, rotate outranks hold.
    function automatic op_e decode_op(input logic load, input logic en);
        if (load) begin
            return OP_LOAD;
        end
        if (en) begin
            return OP_ROT;
        end
        return OP_HOLD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/left_rotate_reg_next.sv
// ============================================================================
// Module      : left_rotate_reg_next
// Description : Combinational next-state mux: load > rotate-left > hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module left_rotate_reg_next
    import left_rotate_reg_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic [DW-1:0] q,
    input  logic [DW-1:0] data,
    input  logic          load,
    input  logic          en,
    output logic [DW-1:0] next_q
);

    op_e w_op;

    assign w_op = decode_op(load, en);

    always_comb begin
        next_q = q;
        case (w_op)
            OP_LOAD: next_q = data;
            OP_ROT:  next_q = `LEFT_ROTATE_REG_ROTL1(q, DW);
            default: next_q = q;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/left_rotate_reg.sv
// ============================================================================
// Module      : left_rotate_reg
// Description : DW-bit parallel-load / rotate-left / hold register with an
//               asynchronous active-high reset. Optional simulation checks are
//               compiled in with LEFT_ROTATE_REG_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module left_rotate_reg
    import left_rotate_reg_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          sync_rst,
    input  logic          load,
    input  logic          en,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] q
);

    logic [DW-1:0] r_q;
    logic [DW-1:0] w_next_q;

    left_rotate_reg_next #(
        .DW (DW)
    ) u_next (
        .q      (r_q),
        .data   (data),
        .load   (load),
        .en     (en),
        .next_q (w_next_q)
    );

    // The port keeps its historical name; the reset really is asynchronous.
    always_ff @(posedge clk or posedge sync_rst) begin
        if (sync_rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_next_q;
        end
    end

    assign q = r_q;

`ifdef LEFT_ROTATE_REG_CHECK_EN
    generate
        if (DW < int'(c_MIN_DW)) begin : g_dw_check
            $error("left_rotate_reg: DW must be at least 2");
        end
    endgenerate

    op_e w_chk_op;

    assign w_chk_op = decode_op(load, en);

    a_ctrl_known: assert property (@(posedge clk) disable iff (sync_rst)
        !$isunknown({load, en}))
        else $error("left_rotate_reg: load/en unknown at clock edge");

    // Previous-edge reset forces zero; otherwise follow the priority rules.
    a_next_state: assert property (@(posedge clk) disable iff (sync_rst)
        $past(sync_rst) ||
        (($past(w_chk_op) == OP_LOAD) ? (q == $past(data)) :
         ($past(w_chk_op) == OP_ROT)  ? (q == {$past(q[DW-2:0]), $past(q[DW-1])}) :
                                        (q == $past(q))))
        else $error("left_rotate_reg: next-state rule violated");
`endif

endmodule

`default_nettype wire

// File: tb/tb_left_rotate_reg.sv
// ============================================================================
// Module      : tb_left_rotate_reg
// Description : Scoreboard bench for left_rotate_reg at DW=4 and DW=8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_left_rotate_reg;

    logic       clk      = 1'b0;
    logic       sync_rst = 1'b1;
    logic       load     = 1'b0;
    logic       en       = 1'b0;
    logic [3:0] d4       = '0;
    logic [7:0] d8       = '0;
    logic [3:0] q4;
    logic [7:0] q8;

    left_rotate_reg #(.DW(4)) u_dut4 (
        .clk      (clk),
        .sync_rst (sync_rst),
        .load     (load),
        .en       (en),
        .data     (d4),
        .q        (q4)
    );

    left_rotate_reg #(.DW(8)) u_dut8 (
        .clk      (clk),
        .sync_rst (sync_rst),
        .load     (load),
        .en       (en),
        .data     (d8),
        .q        (q8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] e4;
        logic [7:0] e8;
        bit         is_async;
    } exp_t;

    exp_t sb[$];
    int   n_chk    = 0;
    int   n_pass   = 0;
    int   m4       = 0;
    int   m8       = 0;
    bit   prev_rst = 1'b1;

    // Reference rotate: double, wrap modulo 2^w, carry the old MSB into bit 0.
    function automatic int ref_rotl(input int v, input int w);
        return ((v * 2) % (1 << w)) + (v / (1 << (w - 1)));
    endfunction

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
        n_chk++;
        if (got !== want) begin
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, got, want);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue what q must be.
    task automatic step(input bit r, input bit ld, input bit e,
                        input logic [3:0] a4, input logic [7:0] a8,
                        input int want4 = -1);
        exp_t x;
        @(negedge clk);
        if (r && !prev_rst) begin
            x.e4 = '0;
            x.e8 = '0;
            x.is_async = 1'b1;
            sb.push_back(x);
        end
        load = ld;
        en   = e;
        d4   = a4;
        d8   = a8;
        if (r) begin
            m4 = 0;
            m8 = 0;
        end else if (ld) begin
            m4 = int'(a4);
            m8 = int'(a8);
        end else if (e) begin
            m4 = ref_rotl(m4, 4);
            m8 = ref_rotl(m8, 8);
        end
        x.e4 = (want4 >= 0) ? want4[3:0] : m4[3:0];
        x.e8 = m8[7:0];
        x.is_async = 1'b0;
        sb.push_back(x);
        sync_rst = r;
        prev_rst = r;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk or posedge sync_rst);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check(x.is_async ? "async_rst_dw4" : "edge_dw4", {4'b0, q4}, {4'b0, x.e4});
                check(x.is_async ? "async_rst_dw8" : "edge_dw8", q8, x.e8);
            end
        end
    end

    initial begin : stimulus
        // Reset held from time zero.
        step(1, 0, 0, 4'h0, 8'h00, 0);
        step(1, 0, 0, 4'h0, 8'h00, 0);

        // Mid-cycle reset clears immediately and dominates load.
        step(0, 1, 0, 4'b1010, 8'hA5, 4'b1010);
        step(1, 1, 0, 4'b1111, 8'hFF, 0);
        step(1, 1, 1, 4'b0110, 8'h3C, 0);

        // Load then hold while data wanders.
        step(0, 1, 0, 4'b1011, 8'hC3, 4'b1011);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 4'($urandom), 8'($urandom), 4'b1011);
        end

        // Four rotates return to the start value.
        step(0, 0, 1, 4'($urandom), 8'($urandom), 4'b0111);
        step(0, 0, 1, 4'($urandom), 8'($urandom), 4'b1110);
        step(0, 0, 1, 4'($urandom), 8'($urandom), 4'b1101);
        step(0, 0, 1, 4'($urandom), 8'($urandom), 4'b1011);

        // Load beats rotate.
        step(0, 0, 1, 4'h0, 8'h00, 4'b0111);
        step(0, 0, 1, 4'h0, 8'h00, 4'b1110);
        step(0, 1, 1, 4'b0101, 8'h81, 4'b0101);
        step(0, 1, 1, 4'b0101, 8'h81, 4'b0101);
        step(0, 0, 1, 4'h0, 8'h00, 4'b1010);

        // Reset abandons a rotation; rotating zero stays zero.
        step(0, 1, 0, 4'b0001, 8'h01, 4'b0001);
        step(0, 0, 1, 4'h0, 8'h00, 4'b0010);
        step(0, 0, 1, 4'h0, 8'h00, 4'b0100);
        step(1, 0, 1, 4'h0, 8'h00, 0);
        step(0, 0, 1, 4'h0, 8'h00, 0);
        step(0, 0, 1, 4'h0, 8'h00, 0);
        step(0, 1, 0, 4'b1000, 8'h80, 4'b1000);
        step(0, 0, 1, 4'h0, 8'h00, 4'b0001);

        // Randomised regression with occasional reset.
        for (int i = 0; i < 1000; i++) begin
            step($urandom_range(0, 31) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1,
                 4'($urandom), 8'($urandom));
        end

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/left_rotate_reg.md
# left_rotate_reg

Parameterised DW-bit register that parallel-loads a data word, circularly rotates its contents left by one bit per enabled clock, and otherwise holds. It is a general datapath building block for bit-serial scheduling, ring-style one-hot sequencing and pattern generation, and sits directly on a single clock domain with no handshake.

## Interface

- DW, default 4: register width in bits. Legal values are DW ≥ 2.
- clk  input  1  rising-edge clock.
- sync_rst  input  1  reset; asynchronous, active-high. The name is kept as-is by codebase convention; the behaviour is asynchronous.
- load  input  1  parallel-load strobe.
- en  input  1  rotate enable.
- data  input  DW  parallel-load value.
- q  output  DW  register contents, driven directly from flops.

## Operation

- State: one DW-bit register driving q.
- Reset: while sync_rst=1, q=0 immediately, independent of clk. Reset dominates load and en.
- Priority at each rising clk edge with sync_rst=0:
  - load=1: q ← data, regardless of en.
  - load=0 and en=1: q ← {q[DW-2:0], q[DW-1]}. This is a left rotate by one; the MSB wraps into bit 0.
  - load=0 and en=0: q holds.
- Wrap-around: DW consecutive rotates return q to its original value. A value of all zeros or all ones is invariant under rotation.
- data is sampled only on edges where load=1. Changes to data at any other time have no effect on q.
- No internal state exists besides q. There are no status outputs.

## Timing

- Latency of one clock: load and rotate results appear on q after the sampling rising edge. q never changes combinationally from load, en or data.
- Reset assertion clears q asynchronously, with no clock required.
- Reset deassertion: the first rising edge with sync_rst=0 is evaluated normally. If load=1 on that edge, q=data after it.
- Reset asserted mid-rotation: the rotation sequence is abandoned and q=0. A later rotate with no new load keeps q=0.
- Load and en held high together on consecutive edges: q reloads data every edge and never rotates.
- Throughput: one operation per cycle, with no back-pressure.

## Configuration

- LEFT_ROTATE_REG_CHECK_EN: when defined, the following simulation-only checks are compiled in:
  - an elaboration-time error if DW < 2;
  - an assertion that load and en are not X or Z at any rising edge while sync_rst=0;
  - a next-state assertion that after each edge q matches the priority rules above (data, rotated previous q, or previous q).
- When it is not defined, no checking logic is present. The synthesised function is identical in both cases.

## Structure

- Shared package left_rotate_reg_pkg holds:
  - a rotl1 function: a DW-generic left rotate by one, written as a parameterised function or macro;
  - an opcode enum {OP_HOLD, OP_ROT, OP_LOAD}, used by the next-state decode and the checkers.
- One sub-module is natural: left_rotate_reg_next. It is a combinational next-state mux that takes q, data, load and en and outputs next_q, using the priority load > en > hold.
- The top-level module instantiates left_rotate_reg_next plus the async-reset flop bank, and holds the optional check block.

## Test plan

- Reset: assert sync_rst mid-cycle with q=4'b1010 → q=4'b0000 immediately, before the next clk edge. q stays 0 while reset is held, even with load=1.
- Load/hold: load=1 with data=4'b1011 and en=0 for one edge, then load=0 while data toggles randomly → q=4'b1011 after the edge and unchanged for 8 cycles.
- Rotate: from q=4'b1011, en=1 and load=0 for 4 edges → q=0111, 1110, 1101, 1011.
- Priority: en=1 and load=1 with data=4'b0101 while q=4'b1110 → q=4'b0101 with no rotation. Keep en=1 and drop load → the next edge gives 4'b1010.
- Reset during rotation: rotating from 4'b0001, assert sync_rst after two edges (q=0100) → q=0. Release reset with en=1 and load=0 → q remains 0000. Load 4'b1000 → the next rotate gives 4'b0001.
- Randomised regression: DW=4 and DW=8, with random load, en, data and occasional reset for 1000 cycles → q matches the reference model on every edge. Run with LEFT_ROTATE_REG_CHECK_EN defined, and require zero assertion failures.
